// File: rtl/mem_access.sv
// mem_access: memory stage issuing byte/half/word loads and stores over a req/ready
// handshake, with lane formatting, timeout abort and a registered writeback bundle.
module mem_access #(
  parameter int TIMEOUT    = 256,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic        regwrite_in,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        addr_err,
  output logic        bus_err
);
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  localparam logic [31:0] TO = 32'(TIMEOUT);
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        rw_q, rw_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_rw_q, wb_rw_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;
  logic        mem_op, accept, illegal, launch, done, expire;
  logic [1:0]  lane_in, lane_q;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  // Lane index counts from the LSB byte; big-endian mirrors the address offset.
  assign lane_in = BIG_ENDIAN ? ~alu_result[1:0] : alu_result[1:0];
  assign lane_q  = BIG_ENDIAN ? ~off_q : off_q;
  assign mem_op  = memread | memwrite;
  assign accept  = (state_q == IDLE) && in_valid;
  assign illegal = (memread & memwrite) || (mem_size == 2'b11) ||
                   (mem_size == 2'b01 && alu_result[0]) ||
                   (mem_size == 2'b10 && alu_result[1:0] != 2'b00);
  assign launch  = accept && mem_op && !illegal;
  assign done    = (state_q == WAIT) && mem_ready;
  assign expire  = (state_q == WAIT) && !mem_ready && (TIMEOUT != 0) && (cnt_q == TO - 32'd1);
  assign be_in    = mem_size == 2'b00 ? 4'b0001 << lane_in :
                    mem_size == 2'b01 ? (lane_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_in = mem_size == 2'b00 ? {4{store_data[7:0]}} :
                    mem_size == 2'b01 ? {2{store_data[15:0]}} : store_data;
  assign ld_byte = 8'(mem_rdata >> {lane_q, 3'b000});
  assign ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ld_data = size_q == 2'b00 ? {{24{~uns_q & ld_byte[7]}}, ld_byte} :
                   size_q == 2'b01 ? {{16{~uns_q & ld_half[15]}}, ld_half} : mem_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      off_q      <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      rw_q       <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      off_q      <= off_d;
      size_q     <= size_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      rw_q       <= rw_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = launch ? WAIT : IDLE;
    else state_d = (done || expire) ? IDLE : WAIT;
  end
  always_comb begin
    addr_d  = launch ? {alu_result[31:2], 2'b00} : addr_q;
    wdata_d = launch ? wdata_in : wdata_q;
    be_d    = launch ? be_in : be_q;
    off_d   = launch ? alu_result[1:0] : off_q;
    size_d  = launch ? mem_size : size_q;
    we_d    = launch ? memwrite : we_q;
    uns_d   = launch ? load_unsigned : uns_q;
    rw_d    = launch ? regwrite_in : rw_q;
    rd_d    = launch ? rd_in : rd_q;
    cnt_d   = ((state_q == WAIT) && !mem_ready && !expire) ? cnt_q + 32'd1 : '0;
  end
  // Writeback: non-mem and illegal ops retire from IDLE, mem ops on done/expire.
  always_comb begin
    wb_valid_d = (accept && (!mem_op || illegal)) || done || expire;
    addr_err_d = accept && mem_op && illegal;
    bus_err_d  = expire;
    wb_rw_d    = accept && !mem_op ? regwrite_in :
                 accept && illegal ? 1'b0 :
                 done ? (rw_q & ~we_q) :
                 expire ? 1'b0 : wb_rw_q;
    wb_rd_d    = accept && (!mem_op || illegal) ? rd_in :
                 (done || expire) ? rd_q : wb_rd_q;
    wb_data_d  = accept && !mem_op ? alu_result :
                 done && !we_q ? ld_data : wb_data_q;
  end
  always_comb begin
    mem_req     = state_q == WAIT;
    stall       = state_q == WAIT;
    mem_we      = we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    mem_be      = be_q;
    wb_valid    = wb_valid_q;
    wb_regwrite = wb_rw_q;
    wb_rd       = wb_rd_q;
    wb_data     = wb_data_q;
    addr_err    = addr_err_q;
    bus_err     = bus_err_q;
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access (TIMEOUT=4, big-endian).
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [1:0]  mem_size = '0;
  logic        load_unsigned = 1'b0;
  logic        regwrite_in = 1'b0;
  logic [4:0]  rd_in = '0;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid, wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        addr_err, bus_err;
  int checks = 0;
  int errors = 0;
  mem_access #(.TIMEOUT(4), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
    .store_data(store_data), .memread(memread), .memwrite(memwrite),
    .mem_size(mem_size), .load_unsigned(load_unsigned), .regwrite_in(regwrite_in),
    .rd_in(rd_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .addr_err(addr_err), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic rd_, input logic wr_, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] sd, input logic rw, input logic [4:0] r);
    in_valid = 1'b1; memread = rd_; memwrite = wr_; mem_size = sz; load_unsigned = un;
    alu_result = a; store_data = sd; regwrite_in = rw; rd_in = r;
    step;
    in_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
  endtask
  task automatic test_reset;
    step;
    checks++;
    if ({stall, mem_req, wb_valid, addr_err, bus_err, wb_regwrite} !== 6'b0 || wb_data !== 32'h0 || mem_be !== 4'h0) begin
      errors++;
      $display("FAIL reset outs got st%0b rq%0b wv%0b ae%0b be%0b data %h want all 0", stall, mem_req, wb_valid, addr_err, bus_err, wb_data);
    end
    rst = 1'b0;
    step;
  endtask
  task automatic test_nonmem;
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1'b1, 5'd5);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h42 || wb_rd !== 5'd5 || wb_regwrite !== 1'b1) begin
      errors++;
      $display("FAIL nonmem_wb got v%0b d%h rd%0d rw%0b want v1 d00000042 rd5 rw1", wb_valid, wb_data, wb_rd, wb_regwrite);
    end
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL nonmem_req got req%0b stall%0b want 0 0", mem_req, stall);
    end
    step;
    checks++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0 || wb_data !== 32'h42) begin
      errors++;
      $display("FAIL nonmem_pulse got v%0b req%0b d%h want v0 req0 d00000042", wb_valid, mem_req, wb_data);
    end
  endtask
  task automatic test_loads;
    logic [31:0] va [5] = '{32'h1001, 32'h1001, 32'h1002, 32'h1000, 32'h1003};
    logic [1:0]  vs [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        vu [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] vr [5] = '{32'h11F23344, 32'h11F23344, 32'h11F28344, 32'h8A2B0000, 32'hAAAAAA7F};
    logic [31:0] ve [5] = '{32'hFFFFFFF2, 32'h000000F2, 32'hFFFF8344, 32'h00008A2B, 32'h0000007F};
    logic [3:0]  vb [5] = '{4'b0100, 4'b0100, 4'b0011, 4'b1100, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, vs[i], vu[i], va[i], 32'h0, 1'b1, 5'd7);
      checks++;
      if (mem_req !== 1'b1 || stall !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h1000 || mem_be !== vb[i]) begin
        errors++;
        $display("FAIL load%0d_req got req%0b st%0b we%0b a%h be%b want 1 1 0 00001000 %b", i, mem_req, stall, mem_we, mem_addr, mem_be, vb[i]);
      end
      step;
      mem_ready = 1'b1; mem_rdata = vr[i];
      step;
      mem_ready = 1'b0; mem_rdata = 32'h0;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== ve[i] || wb_regwrite !== 1'b1 || wb_rd !== 5'd7 || mem_req !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_wb got v%0b d%h rw%0b rd%0d req%0b st%0b want 1 %h 1 7 0 0", i, wb_valid, wb_data, wb_regwrite, wb_rd, mem_req, stall, ve[i]);
      end
      step;
    end
  endtask
  task automatic test_store;
    int st_cycles = 0;
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'hDEADBEEF, 1'b1, 5'd3);
    for (int c = 0; c < 4; c++) begin
      st_cycles += int'(stall);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_be !== 4'b0011 || mem_wdata !== 32'hBEEFBEEF || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL sh_hold%0d got req%0b we%0b a%h be%b wd%h wv%0b want 1 1 00002000 0011 beefbeef 0", c, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid);
      end
      if (c == 3) mem_ready = 1'b1;
      step;
    end
    mem_ready = 1'b0;
    checks++;
    if (st_cycles != 4 || stall !== 1'b0 || wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL sh_done got stallcyc %0d st%0b wv%0b rw%0b req%0b want 4 0 1 0 0", st_cycles, stall, wb_valid, wb_regwrite, mem_req);
    end
    step;
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h2001, 32'h123456A5, 1'b0, 5'd0);
    checks++;
    if (mem_be !== 4'b0100 || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL sb_lane got be%b wd%h a%h want 0100 a5a5a5a5 00002000", mem_be, mem_wdata, mem_addr);
    end
    mem_ready = 1'b1;
    step;
    mem_ready = 1'b0;
    step;
  endtask
  task automatic test_addr_err;
    logic        vr [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        vw [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  vs [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] va [4] = '{32'h3002, 32'h3001, 32'h3000, 32'h3000};
    for (int i = 0; i < 4; i++) begin
      issue(vr[i], vw[i], vs[i], 1'b0, va[i], 32'h0, 1'b1, 5'd9);
      checks++;
      if (addr_err !== 1'b1 || wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL aerr%0d got ae%0b wv%0b rw%0b req%0b st%0b be%0b want 1 1 0 0 0 0", i, addr_err, wb_valid, wb_regwrite, mem_req, stall, bus_err);
      end
      step;
      checks++;
      if (addr_err !== 1'b0 || wb_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL aerr%0d_pulse got ae%0b wv%0b req%0b want 0 0 0", i, addr_err, wb_valid, mem_req);
      end
    end
  endtask
  task automatic test_timeout;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 1'b1, 5'd11);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (mem_req !== 1'b1 || stall !== 1'b1 || bus_err !== 1'b0 || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL to_wait%0d got req%0b st%0b be%0b wv%0b want 1 1 0 0", c, mem_req, stall, bus_err, wb_valid);
      end
      step;
    end
    checks++;
    if (bus_err !== 1'b1 || wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL to_abort got be%0b wv%0b rw%0b req%0b st%0b want 1 1 0 0 0", bus_err, wb_valid, wb_regwrite, mem_req, stall);
    end
    step;
    checks++;
    if (bus_err !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse got be%0b wv%0b want 0 0", bus_err, wb_valid);
    end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h4004, 32'h0, 1'b1, 5'd12);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D; end
      step;
    end
    mem_ready = 1'b0;
    checks++;
    if (bus_err !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D || wb_regwrite !== 1'b1 || wb_rd !== 5'd12) begin
      errors++;
      $display("FAIL to_race got be%0b wv%0b d%h rw%0b rd%0d want 0 1 cafef00d 1 12", bus_err, wb_valid, wb_data, wb_regwrite, wb_rd);
    end
    step;
  endtask
  task automatic test_reset_mid;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 1'b1, 5'd13);
    step;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got req%0b st%0b wv%0b want 0 0 0", mem_req, stall, wb_valid);
    end
    step;
    rst = 1'b0;
    step;
    checks++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_nowb got wv%0b req%0b want 0 0", wb_valid, mem_req);
    end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 5'd14);
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_be !== 4'b1111) begin
      errors++;
      $display("FAIL rst_lw_req got req%0b a%h be%b want 1 00000000 1111", mem_req, mem_addr, mem_be);
    end
    step;
    mem_ready = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h12345678 || wb_rd !== 5'd14 || wb_regwrite !== 1'b1) begin
      errors++;
      $display("FAIL rst_lw_wb got v%0b d%h rd%0d rw%0b want 1 12345678 14 1", wb_valid, wb_data, wb_rd, wb_regwrite);
    end
    step;
  endtask
  initial begin
    test_reset;
    test_nonmem;
    test_loads;
    test_store;
    test_addr_err;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
